axis_cfg_seq: RTL and testbench



---
 rtl/axis_cfg_pkg.sv | 22 ++
 rtl/axis_cfg_seq_if.sv | 24 ++
 rtl/cmd_fifo.sv | 52 +++++
 rtl/axis_cfg_seq.sv | 134 +++++++++++++
 tb/tb_axis_cfg_seq.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/axis_cfg_pkg.sv
// Shared constants and state encoding for the stream-engine configuration sequencer.
// The axis_read/axis_write benches reuse the cfg address constants.
package axis_cfg_pkg;

  localparam int unsigned CONFIG_ADDR = 23;
  localparam int unsigned CONFIG_DATA = 24;
  localparam int unsigned CMD_FIELDS  = 3;

  typedef enum logic [2:0] {
    StIdle,
    StId,
    StAddr,
    StLen,
    StGap
  } seq_state_e;

  // One queue entry holds {id, addr, len}.
  function automatic int unsigned cmd_width(input int unsigned dwidth);
    return CMD_FIELDS * dwidth;
  endfunction

endpackage

// File: rtl/axis_cfg_seq_if.sv
// Command port and cfg-bus signals of the configuration sequencer.
interface axis_cfg_seq_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic [DW-1:0] cmd_id;
  logic [DW-1:0] cmd_addr;
  logic [DW-1:0] cmd_len;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          cfg_valid;

  modport master (
    output cmd_id, cmd_addr, cmd_len, cmd_valid,
    input  cmd_ready, cfg_addr, cfg_data, cfg_valid
  );

  modport slave (
    input  cmd_id, cmd_addr, cmd_len, cmd_valid,
    output cmd_ready, cfg_addr, cfg_data, cfg_valid
  );
endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered ready (not-full) and empty flags.
module cmd_fifo #(
  parameter int unsigned WIDTH  = 96,
  parameter int unsigned AWIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             ready,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             empty_next
);
  localparam int unsigned Depth = 2 ** AWIDTH;

  logic [WIDTH-1:0]  mem_q [Depth];
  logic [AWIDTH-1:0] wptr_q, rptr_q;
  logic [AWIDTH:0]   cnt_q, cnt_d;
  logic              ready_q, empty_q, do_push, do_pop;

  assign do_push    = push & ready_q;
  assign do_pop     = pop & ~empty_q;
  assign cnt_d      = cnt_q + (AWIDTH+1)'(do_push) - (AWIDTH+1)'(do_pop);
  assign ready      = ready_q;
  assign empty      = empty_q;
  assign empty_next = (cnt_d == '0);
  assign rdata      = mem_q[rptr_q];

  // ready_q resets low so no command is taken during the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= wptr_q + AWIDTH'(1);
      if (do_pop)  rptr_q <= rptr_q + AWIDTH'(1);
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != (AWIDTH+1)'(Depth));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/axis_cfg_seq.sv
// Serialises queued stream commands into id/addr/len cfg-bus writes with optional idle gaps.
module axis_cfg_seq
  import axis_cfg_pkg::*;
#(
  parameter int unsigned CMD_AWIDTH    = 2,
  parameter int unsigned CONFIG_AWIDTH = 5,
  parameter int unsigned CONFIG_DWIDTH = 32,
  parameter int unsigned CFG_GAP       = 0
) (
  input  logic         clk,
  input  logic         rst,
  axis_cfg_seq_if.slave bus,
  output logic         busy,
  output logic [15:0]  cmd_done,
  output logic [15:0]  cmd_drop
);
  localparam int unsigned DW      = CONFIG_DWIDTH;
  localparam int unsigned EntryW  = cmd_width(DW);
  localparam logic [3:0]  GapInit = (CFG_GAP > 0) ? 4'(CFG_GAP - 1) : 4'd0;

  seq_state_e        state_q, state_d, after_q, after_d, nxt;
  logic [3:0]        gap_q, gap_d;
  logic [EntryW-1:0] cur_q, cur_d, fifo_rdata;
  logic [15:0]       done_q, done_d, drop_q, drop_d;
  logic              busy_q, pop, take, finish, fifo_empty, fifo_empty_next;

  cmd_fifo #(
    .WIDTH (EntryW),
    .AWIDTH(CMD_AWIDTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.cmd_valid),
    .wdata     ({bus.cmd_id, bus.cmd_addr, bus.cmd_len}),
    .ready     (bus.cmd_ready),
    .pop       (pop),
    .rdata     (fifo_rdata),
    .empty     (fifo_empty),
    .empty_next(fifo_empty_next)
  );

  always_comb begin
    state_d = state_q;
    after_d = after_q;
    gap_d   = gap_q;
    cur_d   = cur_q;
    done_d  = done_q;
    drop_d  = drop_q;
    nxt     = StIdle;
    pop     = 1'b0;
    take    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: take = ~fifo_empty;
      StId, StAddr, StLen: begin
        // nxt == StIdle marks the end of the write set.
        nxt = (state_q == StId) ? StAddr : (state_q == StAddr) ? StLen : StIdle;
        if (CFG_GAP != 0) begin
          state_d = StGap;
          after_d = nxt;
          gap_d   = GapInit;
        end else if (nxt != StIdle) begin
          state_d = nxt;
        end else begin
          finish = 1'b1;
        end
      end
      StGap: begin
        if (gap_q != 4'd0)          gap_d   = gap_q - 4'd1;
        else if (after_q != StIdle) state_d = after_q;
        else                        finish  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (finish) begin
      done_d  = done_q + 16'd1;
      state_d = StIdle;
      take    = ~fifo_empty;
    end
    if (take) begin
      pop = 1'b1;
      if (fifo_rdata[DW-1:0] == '0) begin
        drop_d = drop_q + 16'd1;
      end else begin
        cur_d   = fifo_rdata;
        state_d = StId;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      after_q <= StIdle;
      gap_q   <= '0;
      cur_q   <= '0;
      done_q  <= '0;
      drop_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      after_q <= after_d;
      gap_q   <= gap_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      busy_q  <= (state_d != StIdle) | ~fifo_empty_next;
    end
  end

  always_comb begin
    bus.cfg_valid = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    if (state_q == StId) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_addr  = CONFIG_AWIDTH'(CONFIG_ADDR);
      bus.cfg_data  = cur_q[3*DW-1:2*DW];
    end else if (state_q == StAddr) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_addr  = CONFIG_AWIDTH'(CONFIG_DATA);
      bus.cfg_data  = cur_q[2*DW-1:DW];
    end else if (state_q == StLen) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_addr  = CONFIG_AWIDTH'(CONFIG_DATA);
      bus.cfg_data  = cur_q[DW-1:0];
    end
  end

  assign busy     = busy_q;
  assign cmd_done = done_q;
  assign cmd_drop = drop_q;

endmodule

// File: tb/tb_axis_cfg_seq.sv
// Scoreboard bench: one sequencer with no gap, one with a 3-cycle gap.
module tb_axis_cfg_seq;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy0, busy3;
  logic [15:0] done0, drop0, done3, drop3;
  int unsigned n_tests = 0, n_fail = 0, cyc = 0, last_acc = 0;
  logic        mon_en = 1'b0;
  wr_t         exp0[$], exp3[$];
  int unsigned wcyc0[$], wcyc3[$];
  logic [15:0] m_done[2], m_drop[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_cfg_seq_if #(.AW(5), .DW(32)) bus0 ();
  axis_cfg_seq_if #(.AW(5), .DW(32)) bus3 ();

  axis_cfg_seq #(.CFG_GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .cmd_done(done0), .cmd_drop(drop0)
  );
  axis_cfg_seq #(.CFG_GAP(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .busy(busy3), .cmd_done(done3), .cmd_drop(drop3)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon0
    wr_t e;
    if (mon_en) begin
      if (bus0.cfg_valid === 1'b1) begin
        check_eq("cfg0_valid", bus0.cfg_valid, 64'(exp0.size() != 0));
        if (exp0.size() != 0) begin
          e = exp0.pop_front();
          check_eq("cfg0_addr", bus0.cfg_addr, e.a);
          check_eq("cfg0_data", bus0.cfg_data, e.d);
          wcyc0.push_back(cyc);
        end
      end else begin
        check_eq("cfg0_idle", {bus0.cfg_valid, bus0.cfg_addr, bus0.cfg_data}, 0);
      end
    end
  end

  always @(negedge clk) begin : mon3
    wr_t e;
    if (mon_en) begin
      if (bus3.cfg_valid === 1'b1) begin
        check_eq("cfg3_valid", bus3.cfg_valid, 64'(exp3.size() != 0));
        if (exp3.size() != 0) begin
          e = exp3.pop_front();
          check_eq("cfg3_addr", bus3.cfg_addr, e.a);
          check_eq("cfg3_data", bus3.cfg_data, e.d);
          wcyc3.push_back(cyc);
        end
      end else begin
        check_eq("cfg3_idle", {bus3.cfg_valid, bus3.cfg_addr, bus3.cfg_data}, 0);
      end
    end
  end

  function automatic logic rdy(input bit sel);
    return sel ? bus3.cmd_ready : bus0.cmd_ready;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [31:0] id, addr, len);
    if (sel) begin
      bus3.cmd_valid = v; bus3.cmd_id = id; bus3.cmd_addr = addr; bus3.cmd_len = len;
    end else begin
      bus0.cmd_valid = v; bus0.cmd_id = id; bus0.cmd_addr = addr; bus0.cmd_len = len;
    end
  endtask

  task automatic push(input bit sel, input logic [31:0] id, addr, len);
    int unsigned n = 0;
    @(negedge clk);
    drive(sel, 1'b1, id, addr, len);
    while (rdy(sel) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rdy(sel) !== 1'b1) begin
      check_eq("push_ready", rdy(sel), 1);
      drive(sel, 1'b0, 0, 0, 0);
      return;
    end
    last_acc = cyc + 1;
    if (len == 0) begin
      m_drop[sel] = m_drop[sel] + 16'd1;
    end else begin
      m_done[sel] = m_done[sel] + 16'd1;
      if (sel) begin
        exp3.push_back(wr_t'{a: 5'd23, d: id});
        exp3.push_back(wr_t'{a: 5'd24, d: addr});
        exp3.push_back(wr_t'{a: 5'd24, d: len});
      end else begin
        exp0.push_back(wr_t'{a: 5'd23, d: id});
        exp0.push_back(wr_t'{a: 5'd24, d: addr});
        exp0.push_back(wr_t'{a: 5'd24, d: len});
      end
    end
    @(posedge clk);
    #1 drive(sel, 1'b0, 0, 0, 0);
  endtask

  task automatic wait_idle(input bit sel);
    int unsigned n = 0;
    logic b;
    int unsigned q;
    do begin
      @(negedge clk);
      n++;
      b = sel ? busy3 : busy0;
      q = sel ? exp3.size() : exp0.size();
    end while ((b !== 1'b0 || q != 0) && n < 500);
    check_eq(sel ? "busy3_idle" : "busy0_idle", b, 0);
    check_eq(sel ? "drain3" : "drain0", q, 0);
    check_eq(sel ? "done3" : "done0", sel ? done3 : done0, m_done[sel]);
    check_eq(sel ? "drop3" : "drop0", sel ? drop3 : drop0, m_drop[sel]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;
    m_done = '{16'd0, 16'd0};
    m_drop = '{16'd0, 16'd0};
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);

    // Reset state
    @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    check_eq("rst_ready0", bus0.cmd_ready, 0);
    check_eq("rst_ready3", bus3.cmd_ready, 0);
    check_eq("rst_busy0", busy0, 0);
    check_eq("rst_done0", done0, 0);
    check_eq("rst_drop0", drop0, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rel_ready0", bus0.cmd_ready, 1);
    check_eq("rel_ready3", bus3.cmd_ready, 1);

    // Single command, latency
    wcyc0.delete();
    push(0, 32'd1, 32'd4, 32'd8);
    n = last_acc;
    wait_idle(0);
    check_eq("t1_nwr", wcyc0.size(), 3);
    for (int i = 0; i < wcyc0.size(); i++) check_eq("t1_lat", wcyc0[i], n + 1 + i);

    // Back-to-back
    wcyc0.delete();
    push(0, 32'd1, 32'd4, 32'd20);
    push(0, 32'd2, 32'h100, 32'd16);
    wait_idle(0);
    check_eq("t2_nwr", wcyc0.size(), 6);
    for (int i = 1; i < wcyc0.size(); i++) check_eq("t2_spacing", wcyc0[i] - wcyc0[i-1], 1);

    // Zero-length command between two valid ones
    push(0, 32'd5, 32'h40, 32'd3);
    push(0, 32'd3, 32'd8, 32'd0);
    push(0, 32'd6, 32'h80, 32'd2);
    wait_idle(0);
    check_eq("t4_drop", drop0, 1);

    // Full queue with gap
    wcyc3.delete();
    for (int i = 0; i < 5; i++) push(1, 32'(10 + i), 32'(32'h1000 * (i + 1)), 32'(i + 1));
    @(negedge clk);
    check_eq("t3_ready_low", bus3.cmd_ready, 0);
    push(1, 32'd15, 32'h6000, 32'd6);
    wait_idle(1);
    check_eq("t3_nwr", wcyc3.size(), 18);
    for (int i = 1; i < wcyc3.size(); i++) check_eq("t3_spacing", wcyc3[i] - wcyc3[i-1], 4);

    // Reset during the ADDR write with two commands queued
    push(0, 32'd7, 32'h200, 32'd4);
    push(0, 32'd8, 32'h300, 32'd5);
    push(0, 32'd9, 32'h400, 32'd6);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus0.cfg_valid === 1'b1 && bus0.cfg_addr == 5'd24 && bus0.cfg_data == 32'h200)
               && n < 20);
    check_eq("t5_addr_seen", 64'(n < 20), 1);
    #1;
    rst = 1'b0;
    exp0.delete();
    exp3.delete();
    m_done = '{16'd0, 16'd0};
    m_drop = '{16'd0, 16'd0};
    @(negedge clk);
    check_eq("t5_valid", bus0.cfg_valid, 0);
    check_eq("t5_ready_rst", bus0.cmd_ready, 0);
    check_eq("t5_busy_rst", busy0, 0);
    check_eq("t5_done_rst", done0, 0);
    check_eq("t5_drop_rst", drop0, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_ready_rel", bus0.cmd_ready, 1);
    check_eq("t5_flushed", busy0, 0);
    repeat (5) @(negedge clk);
    check_eq("t5_still_idle", busy0, 0);
    push(0, 32'hA, 32'h500, 32'd7);
    wait_idle(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
